// File: rtl/pwconv_pkg.sv
// Shared definitions for the pointwise-convolution point sequencer:
// FSM state encoding and the packing of INT8 lanes into 32-bit words.
package pwconv_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int WORD_W = LANES * LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_OUT,
    ST_FIN
  } pw_state_t;

endpackage

// File: rtl/pwconv_psum_acc.sv
// Partial-sum accumulator: adds one MAC result per valid beat, 32-bit wrap.
module pwconv_psum_acc
  import pwconv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] acc
);

  // Accumulator register; clear wins over accumulate (they never coincide).
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (valid) begin
      acc <= acc + din;
    end
  end

endmodule

// File: rtl/pwconv_point_seq.sv
// Sequences one output point of a pointwise convolution: for every output
// channel it streams NGROUP activation/weight word pairs to an external
// 4-way MAC, accumulates the MAC results and hands the sum to a consumer.
module pwconv_point_seq
  import pwconv_pkg::*;
#(
  parameter  int NGROUP = 8,
  parameter  int NOC    = 16,
  parameter  int AAW    = 3,
  parameter  int WAW    = 7,
  localparam int OCW    = (NOC > 1) ? $clog2(NOC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AAW-1:0]    act_addr,
  input  logic [WORD_W-1:0] act_rdata,
  output logic [WAW-1:0]    wgt_addr,
  input  logic [WORD_W-1:0] wgt_rdata,
  output logic              mac_en,
  output logic [WORD_W-1:0] mac_data,
  output logic [WORD_W-1:0] mac_weight,
  input  logic [WORD_W-1:0] mac_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [OCW-1:0]    out_oc
);

  pw_state_t      state_reg, state_next;
  logic [AAW-1:0] g_reg, g_next;
  logic [OCW-1:0] oc_reg, oc_next;
  // Running weight base oc*NGROUP, kept as an adder chain instead of a product.
  logic [WAW-1:0] wbase_reg, wbase_next;
  logic           rd_v_reg;
  logic           res_v_reg;
  logic           acc_clear;
  logic [WORD_W-1:0] acc;

  wire issue = (state_reg == ST_ISSUE);

  // State, counters and the two valid pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      g_reg     <= '0;
      oc_reg    <= '0;
      wbase_reg <= '0;
      rd_v_reg  <= 1'b0;
      res_v_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      oc_reg    <= oc_next;
      wbase_reg <= wbase_next;
      rd_v_reg  <= issue;
      res_v_reg <= rd_v_reg;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    oc_next    = oc_reg;
    wbase_next = wbase_reg;
    acc_clear  = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_ISSUE;
          g_next     = '0;
          oc_next    = '0;
          wbase_next = '0;
          acc_clear  = 1'b1;
        end
      end
      ST_ISSUE: begin
        g_next = g_reg + AAW'(1);
        if (g_reg == AAW'(NGROUP - 1)) begin
          g_next     = '0;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Once the read stage is empty the last result lands this cycle,
        // so the sum is final by the time OUT is entered.
        if (!rd_v_reg) begin
          state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (oc_reg != OCW'(NOC - 1)) begin
            oc_next    = oc_reg + OCW'(1);
            wbase_next = wbase_reg + WAW'(NGROUP);
            g_next     = '0;
            acc_clear  = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  pwconv_psum_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .clear (acc_clear),
    .valid (res_v_reg),
    .din   (mac_result),
    .acc   (acc)
  );

  // Outputs; forced quiet while reset is held.
  always_comb begin
    busy       = !rst && (state_reg != ST_IDLE);
    done       = !rst && (state_reg == ST_FIN);
    act_addr   = (!rst && issue) ? g_reg : '0;
    wgt_addr   = (!rst && issue) ? (wbase_reg + WAW'(g_reg)) : '0;
    mac_en     = !rst && rd_v_reg;
    mac_data   = act_rdata;
    mac_weight = wgt_rdata;
    out_valid  = !rst && (state_reg == ST_OUT);
    out_data   = out_valid ? acc : '0;
    out_oc     = out_valid ? oc_reg : '0;
  end

endmodule

// File: tb/tb_pwconv_point_seq.sv
// Randomized bench for pwconv_point_seq with buffer, MAC and reference models.
module tb_pwconv_point_seq;

  localparam int NGROUP = 8;
  localparam int NOC    = 16;
  localparam int AAW    = 3;
  localparam int WAW    = 7;
  localparam int OCW    = 4;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic        busy, done, mac_en, out_valid;
  logic [AAW-1:0] act_addr;
  logic [WAW-1:0] wgt_addr;
  logic [31:0] act_rdata, wgt_rdata, mac_data, mac_weight, mac_result, out_data;
  logic [OCW-1:0] out_oc;

  logic [31:0] act_mem [NGROUP];
  logic [31:0] wgt_mem [NGROUP*NOC];

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] first_out;

  always #5 clk = ~clk;

  pwconv_point_seq #(.NGROUP(NGROUP), .NOC(NOC), .AAW(AAW), .WAW(WAW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .act_addr(act_addr), .act_rdata(act_rdata),
    .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
    .mac_en(mac_en), .mac_data(mac_data), .mac_weight(mac_weight),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_oc(out_oc)
  );

  // Dot product of four packed signed bytes, byte 0 in the top bits.
  function automatic logic signed [31:0] dot4(input logic [31:0] a, input logic [31:0] w);
    logic signed [31:0] s;
    logic signed [7:0]  ab, wb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      ab = a[31-8*i -: 8];
      wb = w[31-8*i -: 8];
      s  = s + ab * wb;
    end
    return s;
  endfunction

  // Expected sum for one output channel straight from the buffers.
  function automatic logic [31:0] exp_point(input int oc);
    logic signed [31:0] s;
    s = 0;
    for (int g = 0; g < NGROUP; g++) s = s + dot4(act_mem[g], wgt_mem[oc*NGROUP+g]);
    return s;
  endfunction

  // Buffers with one-cycle registered read and a 1-cycle external MAC.
  always @(posedge clk) begin
    act_rdata <= act_mem[act_addr];
    wgt_rdata <= wgt_mem[wgt_addr];
    if (mac_en) mac_result <= dot4(mac_data, mac_weight);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int g = 0; g < NGROUP; g++) begin
      case (mode)
        0:       act_mem[g] = 32'h01010101;
        1:       act_mem[g] = 32'h80808080;
        2:       act_mem[g] = 32'h01FE03FC;
        default: act_mem[g] = $urandom;
      endcase
    end
    for (int i = 0; i < NGROUP*NOC; i++) begin
      case (mode)
        0:       wgt_mem[i] = 32'h01010101;
        1:       wgt_mem[i] = 32'h80808080;
        2:       wgt_mem[i] = 32'h0506F908;
        default: wgt_mem[i] = $urandom;
      endcase
    end
  endtask

  // One full point; optional consumer stall on one channel and stray starts.
  task automatic run_point(input string name, input int stall_oc, input bit dbl_start);
    int k, nout, beats, bad_beats, stall_cnt, stall_bad, g, oc;
    logic [31:0] held;
    bit seen_done;
    nout = 0; beats = 0; bad_beats = 0; stall_cnt = 0; stall_bad = 0;
    seen_done = 0; held = '0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    check({name, "_busy_after_start"}, busy, 1);
    while (k < 600 && !seen_done) begin
      if (mac_en) begin
        g  = beats % NGROUP;
        oc = beats / NGROUP;
        if (oc >= NOC || mac_data !== act_mem[g] || mac_weight !== wgt_mem[oc*NGROUP+g])
          bad_beats++;
        beats++;
      end
      start = dbl_start && (k == 3 || k == 40);
      out_ready = 1'b1;
      if (out_valid) begin
        if (int'(out_oc) == stall_oc && stall_cnt < 5) begin
          if (stall_cnt == 0) held = out_data;
          else if (out_data !== held || mac_en) stall_bad++;
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          if (stall_cnt > 0 && int'(out_oc) == stall_oc && out_data !== held) stall_bad++;
          if (nout == 0) first_out = out_data;
          check($sformatf("%s_data_oc%0d", name, nout), out_data, exp_point(nout));
          check($sformatf("%s_oc_idx%0d", name, nout), 32'(out_oc), nout);
          nout++;
        end
      end
      if (done) begin
        seen_done = 1;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    check({name, "_done_seen"}, 32'(seen_done), 1);
    check({name, "_done_cycle"}, k, NOC*(NGROUP+3) + 1 + stall_cnt);
    check({name, "_outputs"}, nout, NOC);
    check({name, "_mac_beats"}, beats, NOC*NGROUP);
    check({name, "_bad_beats"}, bad_beats, 0);
    if (stall_oc >= 0) begin
      check({name, "_stall_cycles"}, stall_cnt, 5);
      check({name, "_stall_hold"}, stall_bad, 0);
    end
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done), 0);
    check({name, "_idle_after"}, 32'(busy), 0);
    $display("point %s: %0d outputs, %0d beats, done at cycle %0d", name, nout, beats, k);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    mac_result = '0;
    fill(0);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mac_en", 32'(mac_en), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_addr", {act_addr, wgt_addr}, 0);
    // start coinciding with reset must be dropped
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("start_during_rst", 32'(busy), 0);

    run_point("ones", -1, 1'b0);
    check("ones_sum", first_out, 32);

    fill(1);
    run_point("neg128", -1, 1'b0);
    check("neg128_sum", first_out, 32'd524288);

    fill(2);
    run_point("mixed_stall", 3, 1'b0);
    check("mixed_sum", first_out, 32'hFFFFFE20);

    fill(3);
    run_point("rand_dblstart", -1, 1'b1);

    // reset in the middle of the issue phase
    fill(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_act_addr_g4", 32'(act_addr), 4);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_mac_en", 32'(mac_en), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 0);
    check("post_rst_mac_en", 32'(mac_en), 0);
    run_point("after_rst", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pwconv_point_seq.md
PWCONV_POINT_SEQ -- requirements
Module: pwconv_point_seq

Interface
REQ-001 SHALL have parameter NGROUP, default 8, meaning 4-channel input groups per output point (32 input channels).
REQ-002 SHALL have parameter NOC, default 16, meaning output channels per point.
REQ-003 SHALL have parameter AAW, default 3, meaning activation address width (clog2 NGROUP).
REQ-004 SHALL have parameter WAW, default 7, meaning weight address width (clog2 NGROUP*NOC).
REQ-005 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to process one output point.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last output channel is accepted.
- act_addr  out  AAW  activation buffer read address; read data returns 1 cycle later.
- act_rdata  in  32  4 packed signed INT8 activations, byte 0 in bits [31:24].
- wgt_addr  out  WAW  weight buffer read address; read data returns 1 cycle later.
- wgt_rdata  in  32  4 packed signed INT8 weights, same packing.
- mac_en  out  1  enable to the external 4-way multiply-add unit, which has 1-cycle latency and holds its output when disabled.
- mac_data  out  32  activation word to the MAC.
- mac_weight  out  32  weight word to the MAC.
- mac_result  in  32  signed MAC sum.
- out_valid  out  1  accumulated result is valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  signed accumulated dot product.
- out_oc  out  clog2(NOC)  output channel index of out_data.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, DRAIN, OUT, FIN.
REQ-007 IDLE SHALL move to ISSUE on start=1, clearing the group counter g, the channel counter oc and the accumulator; start SHALL be ignored in every other state.
REQ-008 ISSUE SHALL drive act_addr=g and wgt_addr=oc*NGROUP+g each cycle, increment g, and move to DRAIN after issuing g=NGROUP-1.
REQ-009 Read-valid pipeline: rd_v(t+1)=issue(t); mac_en=rd_v, mac_data=act_rdata and mac_weight=wgt_rdata combinationally.
REQ-010 Result pipeline: res_v(t+1)=mac_en(t); when res_v=1, acc SHALL become acc+mac_result, 32-bit two's-complement wrap, no saturation.
REQ-011 The MAC output SHALL be used only in cycles where res_v=1.
REQ-012 DRAIN SHALL last until rd_v and res_v are both 0, so the last accumulate has completed, then move to OUT; issue-to-OUT latency SHALL be NGROUP+2 cycles.
REQ-013 OUT SHALL hold out_valid=1 with out_data=acc and out_oc=oc stable until out_ready=1.
REQ-014 On the OUT handshake: if oc<NOC-1, the block SHALL increment oc, clear acc and g, and go to ISSUE; else it SHALL go to FIN.
REQ-015 FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-016 busy SHALL be 1 in ISSUE, DRAIN, OUT and FIN, and 0 in IDLE.
REQ-017 With out_ready tied high, one point SHALL take NOC*(NGROUP+3)+1 cycles from start to done.
REQ-018 mac_en SHALL be 0 in all cycles not carrying valid read data, including IDLE, OUT and FIN.

Reset
REQ-019 rst=1 at any clock edge, including mid-operation, SHALL force IDLE and clear g, oc, acc, rd_v and res_v.
REQ-020 During reset, busy, done, mac_en, out_valid, out_data, out_oc, act_addr and wgt_addr SHALL all be 0.
REQ-021 No partial result SHALL be emitted after reset; start in the same cycle as rst SHALL be ignored.

Structure
REQ-022 The FSM state enum and the packing constants (lanes=4, lane width=8) SHALL live in a shared pwconv package.
REQ-023 The block SHALL contain no multipliers; the MAC stays external.
REQ-024 The accumulate stage MAY be a sub-module named pwconv_psum_acc (clear, valid, in, acc).

Verification
REQ-025 NGROUP=8, NOC=1, all act and weight bytes = 1, out_ready=1: out_data=32, out_oc=0, done exactly 12 cycles after start.
REQ-026 All act bytes = -128, weight bytes = -128: per-beat MAC result 65536, out_data=524288.
REQ-027 NOC=16, out_ready low for 5 cycles at oc=3: out_valid and out_data held stable throughout, no MAC beats issued, oc 4 resumes after the handshake.
REQ-028 rst asserted in ISSUE at g=4: next cycle busy=0, mac_en=0, out_valid=0; a following start yields the full correct sum.
REQ-029 start pulsed while busy: ignored, with address sequence and results identical to the single-start run.
REQ-030 Mixed-sign data (act {1,-2,3,-4}, weight {5,6,-7,8}) per group: out_data = NGROUP*(-60) = -480.
